data_ram_arbiter: RTL
=====================

Name: data_ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data RAM.
- Master 0 is the core LSU data port; master 1 is the debug/loader port.
- Each master uses a req/gnt/rvalid handshake. The arbiter serialises accesses with round-robin fairness, drives the RAM port and routes the response back to its owner.
- Out-of-window addresses and response timeouts are answered locally with an error, so a master is never left hanging.

Parameters:
- RAM_BASE_HI, 16'h0010, value of addr[31:16] that selects the RAM window.
- TIMEOUT, 64, cycles allowed from entering ISSUE until mem_rvalid_i before an error response.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req_i / m1_req_i  in  1  master request; held until gnt.
- m0_gnt_o / m1_gnt_o  out  1  request accepted; single-cycle pulse.
- m0_addr_i / m1_addr_i  in  32  byte address.
- m0_we_i / m1_we_i  in  1  1 = write.
- m0_be_i / m1_be_i  in  4  byte-enable code, passed through unchanged.
- m0_wdata_i / m1_wdata_i  in  32  write data.
- m0_rvalid_o / m1_rvalid_o  out  1  response valid; single-cycle pulse.
- m0_err_o / m1_err_o  out  1  error qualifier; meaningful only while rvalid_o is high.
- m0_rdata_o / m1_rdata_o  out  32  read data; 0 for writes and errors.
- mem_req_o  out  1  RAM request.
- mem_gnt_i  in  1  RAM grant.
- mem_addr_o  out  32  latched address.
- mem_we_o  out  1  latched write enable.
- mem_be_o  out  4  latched byte-enable code.
- mem_wdata_o  out  32  latched write data.
- mem_rvalid_i  in  1  RAM response, given for reads and writes.
- mem_rdata_i  in  32  RAM read data.

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE; all outputs 0; latched fields 0; round-robin pointer set so master 0 wins the first tie. Reset mid-transaction abandons it; no response is ever issued for it.
- Only one transaction is in flight at a time.
- FSM states: IDLE, ISSUE, WAIT_RESP, LOCAL_ERR.
- IDLE, arbitration:
  - If exactly one req is high, that master wins.
  - If both are high, the master not granted last wins.
  - gnt_o to the winner is combinational (state==IDLE & req & selected).
  - On grant: latch addr/we/be/wdata and the owner id, and update the pointer.
  - Next state is ISSUE if addr[31:16]==RAM_BASE_HI, else LOCAL_ERR.
- ISSUE:
  - mem_req_o=1 with the latched fields held stable.
  - On mem_gnt_i=1 go to WAIT_RESP; mem_req_o drops the next cycle.
- WAIT_RESP: on mem_rvalid_i=1, register rdata (forced to 0 if we=1) and go to IDLE.
  - Next cycle: owner rvalid_o=1, err_o=0.
- LOCAL_ERR: one cycle, then IDLE.
  - Next cycle: owner rvalid_o=1, err_o=1, rdata_o=0.
- Timeout:
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE and WAIT_RESP.
  - When it reaches TIMEOUT: drop mem_req_o and go to IDLE.
  - Next cycle: owner rvalid_o=1, err_o=1, rdata_o=0.
  - If mem_rvalid_i arrives in the same cycle the counter hits TIMEOUT, the valid response wins.
- mem_rvalid_i outside WAIT_RESP is ignored and no master sees it.
- rvalid_o/err_o/rdata_o are registered and go to the owner only; the non-owner's outputs stay 0. They are single-cycle pulses; rdata_o returns to 0 afterwards.
- Latency, zero-wait RAM (gnt in the first ISSUE cycle, rvalid one cycle later): gnt_o at T, mem_req_o at T+1, mem_rvalid_i at T+2, rvalid_o at T+3.
- Back-to-back: the FSM is in IDLE during the rvalid_o cycle, so a new gnt_o may occur in that same cycle.
- A master may drop req before gnt without effect. Request fields are sampled only at grant.

Test Plan:
- m0 reads addr 0x0010_0004, RAM grants at once and returns 0xDEADBEEF one cycle later → m0_gnt_o at T, mem_req_o at T+1, m0_rvalid_o at T+3 with rdata 0xDEADBEEF, err 0; all m1 outputs stay 0.
- m0 and m1 request continuously from reset → grants alternate m0, m1, m0, m1, each master receives exactly its own responses, and mem_addr_o matches the owner's address.
- m1 writes addr 0x0020_0000 → no mem_req_o; m1_rvalid_o with m1_err_o=1 and rdata 0 two cycles after m1_gnt_o.
- m0 read with mem_gnt_i held low and TIMEOUT=64 → mem_req_o high 64 cycles then low; m0_rvalid_o + m0_err_o one cycle later. A second run with mem_rvalid_i landing in the timeout cycle → normal response, err 0.
- Write 0x11223344 with be 4'b0001 → mem_we_o=1, mem_be_o=0001, mem_wdata_o=0x11223344; response rdata 0, err 0.
- Assert rst_n low while in WAIT_RESP, then release; a late mem_rvalid_i arrives → no rvalid_o on either master, all outputs 0, and the next tie is granted to m0.

Source files
------------

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM port.
// master: the requester / RAM side of the bundle.
// slave:  the arbiter's view of the bundle.
interface data_ram_arbiter_if;
   logic        m0_req;
   logic        m0_gnt;
   logic [31:0] m0_addr;
   logic        m0_we;
   logic [3:0]  m0_be;
   logic [31:0] m0_wdata;
   logic        m0_rvalid;
   logic        m0_err;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_gnt;
   logic [31:0] m1_addr;
   logic        m1_we;
   logic [3:0]  m1_be;
   logic [31:0] m1_wdata;
   logic        m1_rvalid;
   logic        m1_err;
   logic [31:0] m1_rdata;

   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output m0_req, m0_addr, m0_we, m0_be, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_err, m0_rdata,
      output m1_req, m1_addr, m1_we, m1_be, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_err, m1_rdata,
      input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  m0_req, m0_addr, m0_we, m0_be, m0_wdata,
      output m0_gnt, m0_rvalid, m0_err, m0_rdata,
      input  m1_req, m1_addr, m1_we, m1_be, m1_wdata,
      output m1_gnt, m1_rvalid, m1_err, m1_rdata,
      output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of the single-ported data RAM.
// One transaction in flight; out-of-window addresses and RAM timeouts get a local error.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | arbitrate, combinational gnt to the winner, latch its fields
// ISSUE     | mem_req high with latched fields, waiting for mem_gnt
// WAIT_RESP | RAM accepted, waiting for mem_rvalid
// LOCAL_ERR | address outside the RAM window, error answered next cycle
module data_ram_arbiter #(
   parameter logic [15:0] RAM_BASE_HI = 16'h0010,
   parameter int unsigned TIMEOUT     = 64,
   parameter int unsigned CNT_W       = 7
) (
   input logic               clk,
   input logic               rst_n,
   data_ram_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] WAIT_RESP = 2'd2;
   localparam logic [1:0] LOCAL_ERR = 2'd3;

   logic [1:0]       state, state_nxt;
   logic             last;   // id granted most recently; reset to 1 so m0 wins the first tie
   logic             owner;
   logic [31:0]      lat_addr, lat_wdata;
   logic             lat_we;
   logic [3:0]       lat_be;
   logic [CNT_W-1:0] cnt;

   logic             sel1, gnt0, gnt1, granted, in_window;
   logic             timed_out, resp_ok, resp_fire;
   logic [31:0]      win_addr;

   logic             m0_rvalid_q, m0_err_q, m1_rvalid_q, m1_err_q;
   logic [31:0]      m0_rdata_q, m1_rdata_q;

   // Arbitration and response qualification.
   always_comb begin
      sel1      = bus.m1_req & (~bus.m0_req | ~last);
      gnt0      = (state == IDLE) & bus.m0_req & ~sel1;
      gnt1      = (state == IDLE) & sel1;
      granted   = gnt0 | gnt1;
      win_addr  = sel1 ? bus.m1_addr : bus.m0_addr;
      in_window = (win_addr[31:16] == RAM_BASE_HI);
      timed_out = ((state == ISSUE) || (state == WAIT_RESP)) && (cnt == CNT_W'(TIMEOUT));
      // A valid response in the timeout cycle still wins over the timeout.
      resp_ok   = (state == WAIT_RESP) & bus.mem_rvalid;
      resp_fire = resp_ok | timed_out | (state == LOCAL_ERR);
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (granted) state_nxt = in_window ? ISSUE : LOCAL_ERR;
         ISSUE:     if (timed_out) state_nxt = IDLE;
                    else if (bus.mem_gnt) state_nxt = WAIT_RESP;
         WAIT_RESP: if (resp_ok || timed_out) state_nxt = IDLE;
         LOCAL_ERR: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // State, grant pointer, latched request fields and timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         lat_addr  <= '0;
         lat_we    <= 1'b0;
         lat_be    <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
      end else begin
         state <= state_nxt;
         if (granted) begin
            owner     <= sel1;
            last      <= sel1;
            lat_addr  <= win_addr;
            lat_we    <= sel1 ? bus.m1_we    : bus.m0_we;
            lat_be    <= sel1 ? bus.m1_be    : bus.m0_be;
            lat_wdata <= sel1 ? bus.m1_wdata : bus.m0_wdata;
            cnt       <= '0;
         end else if ((state == ISSUE) || (state == WAIT_RESP)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Registered response, routed to the owner only; single-cycle pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid_q <= 1'b0;
         m0_err_q    <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rvalid_q <= 1'b0;
         m1_err_q    <= 1'b0;
         m1_rdata_q  <= '0;
      end else begin
         m0_rvalid_q <= resp_fire & ~owner;
         m0_err_q    <= resp_fire & ~owner & ~resp_ok;
         m0_rdata_q  <= (resp_ok & ~owner & ~lat_we) ? bus.mem_rdata : '0;
         m1_rvalid_q <= resp_fire & owner;
         m1_err_q    <= resp_fire & owner & ~resp_ok;
         m1_rdata_q  <= (resp_ok & owner & ~lat_we) ? bus.mem_rdata : '0;
      end
   end

   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.m0_rvalid = m0_rvalid_q;
   assign bus.m0_err    = m0_err_q;
   assign bus.m0_rdata  = m0_rdata_q;
   assign bus.m1_rvalid = m1_rvalid_q;
   assign bus.m1_err    = m1_err_q;
   assign bus.m1_rdata  = m1_rdata_q;

   assign bus.mem_req   = (state == ISSUE) & ~timed_out;
   assign bus.mem_addr  = lat_addr;
   assign bus.mem_we    = lat_we;
   assign bus.mem_be    = lat_be;
   assign bus.mem_wdata = lat_wdata;

endmodule
